// File: rtl/tile_scene_renderer.sv
// Tile maze scene streamer: emits CASET/RASET/RAMWR then RGB888 pixels
// for a tile window, one byte per transmitter handshake.
module tile_scene_renderer #(
  parameter int          COLS         = 10,
  parameter int          ROWS         = 15,
  parameter int          TILE_LOG2    = 5,
  parameter int          WALL_W       = 4,
  parameter int          FOOD_SIZE    = 8,
  parameter int          PLAYER_SIZE  = 16,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter logic [23:0] WALL_COLOR   = 24'h0078A5,
  parameter logic [23:0] FOOD1_COLOR  = 24'hFFA500,
  parameter logic [23:0] FOOD2_COLOR  = 24'hFFC0CB,
  parameter logic [23:0] FOOD3_COLOR  = 24'hFF0000,
  parameter logic [23:0] PLAYER_COLOR = 24'hFFFF00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  win_x0,
  input  logic [7:0]                  win_x1,
  input  logic [7:0]                  win_y0,
  input  logic [7:0]                  win_y1,
  input  logic [ROWS*(COLS-1)-1:0]    v_walls,
  input  logic [COLS*(ROWS-1)-1:0]    h_walls,
  input  logic [2*ROWS*COLS-1:0]      food,
  input  logic                        player_en,
  input  logic [7:0]                  player_x,
  input  logic [7:0]                  player_y,
  input  logic                        tft_busy,
  output logic                        tft_dc,
  output logic [7:0]                  tft_data,
  output logic                        tft_transmit,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int T   = 1 << TILE_LOG2;
  localparam int VW  = ROWS * (COLS - 1);
  localparam int HW  = COLS * (ROWS - 1);
  localparam int FW  = 2 * ROWS * COLS;
  localparam int FLO = T / 2 - FOOD_SIZE / 2;
  localparam int FHI = T / 2 + FOOD_SIZE / 2;
  localparam int PLO = T / 2 - PLAYER_SIZE / 2;
  localparam int PHI = T / 2 + PLAYER_SIZE / 2;
  localparam int XB  = $clog2(COLS * T);
  localparam int YB  = $clog2(ROWS * T);
  localparam int PWR = (XB > YB) ? XB : YB;
  localparam int PW  = (PWR > 9) ? PWR : 9;

  typedef enum logic [1:0] {IDLE, CMD, PIXEL, FIN} state_t;

  state_t        state;
  logic [3:0]    cmd_idx;
  logic [PW-1:0] px, py;
  logic [1:0]    byte_sel;
  logic [23:0]   color;
  logic [7:0]    wx0, wx1, wy0, wy1;
  logic          pl_en;
  logic [7:0]    pl_x, pl_y;

  logic [15:0]   xs0, xs1, ys0, ys1;
  logic [7:0]    cmd_byte;
  logic          cmd_dc;
  logic          can_issue;
  logic          win_ok;

  assign can_issue = !tft_busy && !tft_transmit;

  assign win_ok = (win_x0 <= win_x1) && (int'(win_x1) < COLS) &&
                  (win_y0 <= win_y1) && (int'(win_y1) < ROWS);

  assign xs0 = {8'd0, wx0} << TILE_LOG2;
  assign xs1 = (({8'd0, wx1} + 16'd1) << TILE_LOG2) - 16'd1;
  assign ys0 = {8'd0, wy0} << TILE_LOG2;
  assign ys1 = (({8'd0, wy1} + 16'd1) << TILE_LOG2) - 16'd1;

  always_comb begin
    cmd_byte = 8'h2C;
    case (cmd_idx)
      4'd0:    cmd_byte = 8'h2A;
      4'd1:    cmd_byte = xs0[15:8];
      4'd2:    cmd_byte = xs0[7:0];
      4'd3:    cmd_byte = xs1[15:8];
      4'd4:    cmd_byte = xs1[7:0];
      4'd5:    cmd_byte = 8'h2B;
      4'd6:    cmd_byte = ys0[15:8];
      4'd7:    cmd_byte = ys0[7:0];
      4'd8:    cmd_byte = ys1[15:8];
      4'd9:    cmd_byte = ys1[7:0];
      default: cmd_byte = 8'h2C;
    endcase
    cmd_dc = !(cmd_idx == 4'd0 || cmd_idx == 4'd5 || cmd_idx == 4'd10);
  end

  int          ci, ri, lx, ly;
  logic [VW-1:0] vl_t, vr_t;
  logic [HW-1:0] ht_t, hb_t;
  logic [FW-1:0] f_t;
  logic        is_pl, is_food, is_wall;
  logic [23:0] pix_color;

  // Neighbour wall bits are pulled out by shifting so indices stay plain ints.
  always_comb begin
    ci   = int'(px) >> TILE_LOG2;
    ri   = int'(py) >> TILE_LOG2;
    lx   = int'(px) & (T - 1);
    ly   = int'(py) & (T - 1);
    vl_t = v_walls >> (ri * (COLS - 1) + ci - 1);
    vr_t = v_walls >> (ri * (COLS - 1) + ci);
    ht_t = h_walls >> ((ri - 1) * COLS + ci);
    hb_t = h_walls >> (ri * COLS + ci);
    f_t  = food >> (2 * (ri * COLS + ci));
    is_pl = pl_en && (ci == int'(pl_x)) && (ri == int'(pl_y)) &&
            (lx >= PLO) && (lx < PHI) && (ly >= PLO) && (ly < PHI);
    is_food = (f_t[1:0] != 2'd0) &&
              (lx >= FLO) && (lx < FHI) && (ly >= FLO) && (ly < FHI);
    is_wall = ((lx < WALL_W) && (ci == 0 || vl_t[0])) ||
              ((lx >= T - WALL_W) && (ci == COLS - 1 || vr_t[0])) ||
              ((ly < WALL_W) && (ri == 0 || ht_t[0])) ||
              ((ly >= T - WALL_W) && (ri == ROWS - 1 || hb_t[0]));
    pix_color = BG_COLOR;
    if (is_pl) begin
      pix_color = PLAYER_COLOR;
    end else if (is_food) begin
      case (f_t[1:0])
        2'd1:    pix_color = FOOD1_COLOR;
        2'd2:    pix_color = FOOD2_COLOR;
        default: pix_color = FOOD3_COLOR;
      endcase
    end else if (is_wall) begin
      pix_color = WALL_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tft_transmit <= 1'b0;
      tft_dc       <= 1'b1;
      tft_data     <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cmd_idx      <= 4'd0;
      px           <= '0;
      py           <= '0;
      byte_sel     <= 2'd0;
      color        <= 24'd0;
      wx0          <= 8'd0;
      wx1          <= 8'd0;
      wy0          <= 8'd0;
      wy1          <= 8'd0;
      pl_en        <= 1'b0;
      pl_x         <= 8'd0;
      pl_y         <= 8'd0;
    end else begin
      tft_transmit <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle swallows any start arriving alongside it.
          if (start && !done) begin
            if (win_ok) begin
              wx0     <= win_x0;
              wx1     <= win_x1;
              wy0     <= win_y0;
              wy1     <= win_y1;
              pl_en   <= player_en;
              pl_x    <= player_x;
              pl_y    <= player_y;
              cmd_idx <= 4'd0;
              busy    <= 1'b1;
              state   <= CMD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CMD: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            tft_dc       <= cmd_dc;
            tft_data     <= cmd_byte;
            if (cmd_idx == 4'd10) begin
              px       <= PW'(xs0);
              py       <= PW'(ys0);
              byte_sel <= 2'd0;
              state    <= PIXEL;
            end else begin
              cmd_idx <= cmd_idx + 4'd1;
            end
          end
        end
        PIXEL: begin
          if (can_issue) begin
            tft_transmit <= 1'b1;
            tft_dc       <= 1'b1;
            case (byte_sel)
              2'd0: begin
                tft_data <= pix_color[23:16];
                color    <= pix_color;
              end
              2'd1:    tft_data <= color[15:8];
              default: tft_data <= color[7:0];
            endcase
            if (byte_sel == 2'd2) begin
              byte_sel <= 2'd0;
              if (px == PW'(xs1) && py == PW'(ys1)) begin
                state <= FIN;
              end else if (px == PW'(xs1)) begin
                px <= PW'(xs0);
                py <= py + PW'(1);
              end else begin
                px <= px + PW'(1);
              end
            end else begin
              byte_sel <= byte_sel + 2'd1;
            end
          end
        end
        default: begin
          if (can_issue) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
